// File: rtl/ltpi_pkg.sv
// LTPI shared definitions: base frame layout, comma code points and frame geometry.
package ltpi_pkg;

   localparam int unsigned FRM_DATA_BYTES = 13;
   localparam int unsigned BYTE_W         = 8;

   // Offset of the last symbol (the CRC byte); a frame is frame_length+1 symbols.
   localparam logic [3:0] frame_length = 4'd15;

   // Comma characters (K28.5 / K28.6) as unencoded bytes.
   localparam logic [BYTE_W-1:0] K28_5 = 8'hBC;
   localparam logic [BYTE_W-1:0] K28_6 = 8'hDC;

   // CRC-8 generator x^8 + x^2 + x + 1, MSB first, zero init.
   localparam logic [BYTE_W-1:0] CRC8_POLY = 8'h07;

   typedef struct packed {
      logic [BYTE_W-1:0]                     comma_symbol;
      logic [BYTE_W-1:0]                     frame_subtype;
      logic [FRM_DATA_BYTES-1:0][BYTE_W-1:0] data;
   } LTPI_base_Frm_t;

   // Bit-reverse a byte (used for reflected CRC variants).
   function automatic logic [BYTE_W-1:0] bit_rev8(input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc8.sv
// Byte-wide CRC-8 update step: returns the CRC after absorbing one data byte.
module crc8
   import ltpi_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [7:0] data_in,
   output logic [7:0] crc_out_c
);

   logic [7:0] work_c;

   // Eight unrolled shift/XOR steps of the polynomial division.
   always_comb begin
      work_c = crc_in ^ data_in;
      for (int i = 0; i < 8; i++) begin
         if (work_c[7]) begin
            work_c = {work_c[6:0], 1'b0} ^ CRC8_POLY;
         end else begin
            work_c = {work_c[6:0], 1'b0};
         end
      end
      crc_out_c = work_c;
   end

endmodule

// File: rtl/encoder_8b10b.sv
// 8b10b encoder: combinational 5b/6b and 3b/4b tables plus the running-disparity flop.
// code_c is abcdei_fghj with a in bit 9. Only K28.y control characters are supported.
module encoder_8b10b (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enc_en,
   input  logic [7:0] data_in,
   input  logic       k_in,
   output logic [9:0] code_c
);

   // RD- column of the 5b/6b table (abcdei).
   function automatic logic [5:0] enc6_neg(input logic [4:0] x);
      logic [5:0] c;
      case (x)
         5'd0:  c = 6'b100111;   5'd1:  c = 6'b011101;
         5'd2:  c = 6'b101101;   5'd3:  c = 6'b110001;
         5'd4:  c = 6'b110101;   5'd5:  c = 6'b101001;
         5'd6:  c = 6'b011001;   5'd7:  c = 6'b111000;
         5'd8:  c = 6'b111001;   5'd9:  c = 6'b100101;
         5'd10: c = 6'b010101;   5'd11: c = 6'b110100;
         5'd12: c = 6'b001101;   5'd13: c = 6'b101100;
         5'd14: c = 6'b011100;   5'd15: c = 6'b010111;
         5'd16: c = 6'b011011;   5'd17: c = 6'b100011;
         5'd18: c = 6'b010011;   5'd19: c = 6'b110010;
         5'd20: c = 6'b001011;   5'd21: c = 6'b101010;
         5'd22: c = 6'b011010;   5'd23: c = 6'b111010;
         5'd24: c = 6'b110011;   5'd25: c = 6'b100110;
         5'd26: c = 6'b010110;   5'd27: c = 6'b110110;
         5'd28: c = 6'b001110;   5'd29: c = 6'b101110;
         5'd30: c = 6'b011110;   default: c = 6'b101011;
      endcase
      return c;
   endfunction

   // RD- column of the data 3b/4b table (fghj), primary x.7.
   function automatic logic [3:0] enc4d_neg(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0: c = 4'b1011;  3'd1: c = 4'b1001;
         3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
         3'd6: c = 4'b0110;  default: c = 4'b1110;
      endcase
      return c;
   endfunction

   // RD- column of the control 3b/4b table (K28.y).
   function automatic logic [3:0] enc4k_neg(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0: c = 4'b1011;  3'd1: c = 4'b0110;
         3'd2: c = 4'b1010;  3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;  3'd5: c = 4'b0101;
         3'd6: c = 4'b1001;  default: c = 4'b0111;
      endcase
      return c;
   endfunction

   logic       rd_q, rd_d;       // 1 = RD+
   logic [4:0] x5_c;
   logic [2:0] y3_c;
   logic [5:0] six_m_c, six_c;
   logic [3:0] four_m_c, four_c;
   logic       rd_mid_c, flip6_c, flip4_c, use_a7_c;

   // Table lookup in RD- form, then complement sub-blocks that alternate when RD+.
   always_comb begin
      x5_c     = data_in[4:0];
      y3_c     = data_in[7:5];
      six_m_c  = k_in ? 6'b001111 : enc6_neg(x5_c);
      flip6_c  = ($countones(six_m_c) != 3) || (!k_in && (x5_c == 5'd7));
      six_c    = (rd_q && flip6_c) ? ~six_m_c : six_m_c;
      rd_mid_c = ($countones(six_m_c) != 3) ? ~rd_q : rd_q;
      // Alternate x.7 avoids a run of five identical bits across the sub-block boundary.
      use_a7_c = !k_in && (y3_c == 3'd7) &&
                 ((!rd_mid_c && ((x5_c == 5'd17) || (x5_c == 5'd18) || (x5_c == 5'd20))) ||
                  ( rd_mid_c && ((x5_c == 5'd11) || (x5_c == 5'd13) || (x5_c == 5'd14))));
      if (k_in) begin
         four_m_c = enc4k_neg(y3_c);
      end else if (use_a7_c) begin
         four_m_c = 4'b0111;
      end else begin
         four_m_c = enc4d_neg(y3_c);
      end
      flip4_c  = k_in || ($countones(four_m_c) != 2) || (y3_c == 3'd3);
      four_c   = (rd_mid_c && flip4_c) ? ~four_m_c : four_m_c;
      rd_d     = rd_q;
      if (enc_en) begin
         rd_d = ($countones(four_m_c) != 2) ? ~rd_mid_c : rd_mid_c;
      end
      code_c   = {six_c, four_c};
   end

   // Running disparity advances only when a symbol is actually consumed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q <= 1'b0;
      end else begin
         rd_q <= rd_d;
      end
   end

endmodule

// File: rtl/ltpi_phy_tx.sv
// LTPI PHY transmit framer: snapshots a base frame, serialises comma/subtype/data/CRC
// one byte per symbol request, and 8b10b-encodes each byte into a registered output.
module ltpi_phy_tx
   import ltpi_pkg::*;
#(
   parameter int CRC_REFLECTOR = 0
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           tx_enable,
   input  LTPI_base_Frm_t ltpi_frame_tx,
   input  logic           sym_req,
   output logic           frame_latched,
   output logic [3:0]     tx_frm_offset,
   output logic           phy_tx_dv,
   output logic [9:0]     phy_tx_out,
   output logic [7:0]     frame_crc
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   state_e                                 state_q, state_d;
   logic [3:0]                             offset_q, offset_d;
   logic [BYTE_W-1:0]                      snap_sub_q, snap_sub_d;
   logic [FRM_DATA_BYTES-1:0][BYTE_W-1:0]  snap_data_q, snap_data_d;
   logic [7:0]                             crc_q, crc_d;
   logic [7:0]                             frame_crc_q, frame_crc_d;
   logic                                   dv_q, dv_d;
   logic [9:0]                             out_q, out_d;
   logic                                   latched_q, latched_d;

   logic                                   accept_c;
   logic [7:0]                             comma_c;
   logic [7:0]                             crc_tx_c;
   logic [7:0]                             tx_byte_c;
   logic                                   tx_k_c;
   logic [3:0]                             data_idx_c;
   logic [7:0]                             crc_data_c;
   logic [7:0]                             crc_next_c;
   logic [9:0]                             enc_code_c;

   assign accept_c = (state_q == ST_SEND) && sym_req;

   // Comma sanitising and CRC reflection on both the input byte and the transmitted result.
   always_comb begin
      comma_c = K28_5;
      if ((ltpi_frame_tx.comma_symbol == K28_5) || (ltpi_frame_tx.comma_symbol == K28_6)) begin
         comma_c = ltpi_frame_tx.comma_symbol;
      end
      crc_tx_c   = (CRC_REFLECTOR != 0) ? bit_rev8(crc_q) : crc_q;
      crc_data_c = (CRC_REFLECTOR != 0) ? bit_rev8(tx_byte_c) : tx_byte_c;
   end

   // Byte selection by frame offset; the comma comes live because the snapshot lands with it.
   always_comb begin
      tx_byte_c  = '0;
      tx_k_c     = 1'b0;
      data_idx_c = offset_q - 4'd2;
      case (offset_q)
         4'd0: begin
            tx_byte_c = comma_c;
            tx_k_c    = 1'b1;
         end
         4'd1:         tx_byte_c = snap_sub_q;
         frame_length: tx_byte_c = crc_tx_c;
         default:      tx_byte_c = snap_data_q[data_idx_c];
      endcase
   end

   crc8 u_crc8 (
      .crc_in    (crc_q),
      .data_in   (crc_data_c),
      .crc_out_c (crc_next_c)
   );

   encoder_8b10b u_enc (
      .clk     (clk),
      .reset_n (reset_n),
      .enc_en  (accept_c),
      .data_in (tx_byte_c),
      .k_in    (tx_k_c),
      .code_c  (enc_code_c)
   );

   // Next-state and output logic. crc_q is advanced on every payload accept, so at the
   // CRC offset it already holds the complete value even with back-to-back requests.
   always_comb begin
      state_d     = state_q;
      offset_d    = offset_q;
      snap_sub_d  = snap_sub_q;
      snap_data_d = snap_data_q;
      crc_d       = crc_q;
      frame_crc_d = frame_crc_q;
      dv_d        = 1'b0;
      out_d       = out_q;
      latched_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            offset_d = '0;
            if (tx_enable) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (sym_req) begin
               dv_d  = 1'b1;
               out_d = enc_code_c;
               if (offset_q == 4'd0) begin
                  latched_d   = 1'b1;
                  snap_sub_d  = ltpi_frame_tx.frame_subtype;
                  snap_data_d = ltpi_frame_tx.data;
                  crc_d       = '0;
               end else if (offset_q == frame_length) begin
                  frame_crc_d = crc_tx_c;
               end else begin
                  crc_d = crc_next_c;
               end
               if (offset_q == frame_length) begin
                  offset_d = '0;
                  if (!tx_enable) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  offset_d = offset_q + 4'd1;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            offset_d = '0;
         end
      endcase
   end

   // State, snapshot, CRC and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         offset_q    <= '0;
         snap_sub_q  <= '0;
         snap_data_q <= '0;
         crc_q       <= '0;
         frame_crc_q <= '0;
         dv_q        <= 1'b0;
         out_q       <= '0;
         latched_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         snap_sub_q  <= snap_sub_d;
         snap_data_q <= snap_data_d;
         crc_q       <= crc_d;
         frame_crc_q <= frame_crc_d;
         dv_q        <= dv_d;
         out_q       <= out_d;
         latched_q   <= latched_d;
      end
   end

   assign frame_latched = latched_q;
   assign tx_frm_offset = offset_q;
   assign phy_tx_dv     = dv_q;
   assign phy_tx_out    = out_q;
   assign frame_crc     = frame_crc_q;

endmodule

// File: tb/tb_ltpi_phy_tx.sv
// Bench for ltpi_phy_tx: vector table, directed corner sequences and a random run, all
// checked every cycle against a frame-level reference model.
module tb_ltpi_phy_tx;
   import ltpi_pkg::*;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           tx_enable;
   LTPI_base_Frm_t frm;
   logic           sym_req;
   logic           frame_latched;
   logic [3:0]     tx_frm_offset;
   logic           phy_tx_dv;
   logic [9:0]     phy_tx_out;
   logic [7:0]     frame_crc;

   always #5 clk = ~clk;

   ltpi_phy_tx #(.CRC_REFLECTOR(0)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .tx_enable     (tx_enable),
      .ltpi_frame_tx (frm),
      .sym_req       (sym_req),
      .frame_latched (frame_latched),
      .tx_frm_offset (tx_frm_offset),
      .phy_tx_dv     (phy_tx_dv),
      .phy_tx_out    (phy_tx_out),
      .frame_crc     (frame_crc)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // 8b10b code tables, both disparity columns as listed in the standard.
   logic [5:0] six_n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                              6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                              6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                              6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                              6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                              6'b011110, 6'b101011};
   logic [5:0] six_p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
                              6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
                              6'b001101, 6'b101100, 6'b011100, 6'b101000, 6'b100100, 6'b100011,
                              6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                              6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
                              6'b100001, 6'b010100};
   logic [3:0] d4_n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] d4_p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
   logic [3:0] k4_n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
   logic [3:0] k4_p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

   // Reference model state
   bit         m_active;
   int         m_off;
   bit         m_rd;               // 1 = RD+
   logic [7:0] m_bytes [16];
   logic [9:0] m_out;
   logic [7:0] m_crc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Whole frame as transmitted: sanitised comma, subtype, data, CRC-8 over offsets 1..14.
   task automatic frame_bytes(input LTPI_base_Frm_t f, output logic [7:0] b [16]);
      logic [7:0] crc;
      logic       fb;
      b[0] = ((f.comma_symbol == K28_5) || (f.comma_symbol == K28_6)) ? f.comma_symbol : K28_5;
      b[1] = f.frame_subtype;
      for (int i = 0; i < 13; i++) b[2+i] = f.data[i];
      crc = 8'h00;
      for (int i = 1; i < 15; i++) begin
         for (int j = 7; j >= 0; j--) begin
            fb  = crc[7] ^ b[i][j];
            crc = {crc[6:0], 1'b0};
            if (fb) crc = crc ^ 8'h07;
         end
      end
      b[15] = crc;
   endtask

   // Encode one byte at the model's running disparity and update it.
   function automatic logic [9:0] ref_enc(input logic [7:0] b, input bit k);
      int         x, y;
      logic [5:0] s;
      logic [3:0] f;
      bit         rdm, a7;
      x = int'(b[4:0]);
      y = int'(b[7:5]);
      if (k) s = m_rd ? 6'b110000 : 6'b001111;
      else   s = m_rd ? six_p[x] : six_n[x];
      rdm = ($countones(s) == 3) ? m_rd : ($countones(s) == 4);
      if (k) begin
         f = rdm ? k4_p[y] : k4_n[y];
      end else begin
         a7 = (y == 7) && ((!rdm && (x == 17 || x == 18 || x == 20)) ||
                           ( rdm && (x == 11 || x == 13 || x == 14)));
         if (a7) f = rdm ? 4'b1000 : 4'b0111;
         else    f = rdm ? d4_p[y] : d4_n[y];
      end
      if ($countones({s, f}) == 6) m_rd = 1'b1;
      else if ($countones({s, f}) == 4) m_rd = 1'b0;
      return {s, f};
   endfunction

   // One clock: apply inputs, advance the model, then compare all outputs after the edge.
   task automatic cycle(input bit en, input bit req);
      bit e_dv, e_lat;
      tx_enable = en;
      sym_req   = req;
      e_dv  = 1'b0;
      e_lat = 1'b0;
      if (!m_active) begin
         if (en) m_active = 1'b1;
      end else if (req) begin
         if (m_off == 0) begin
            frame_bytes(frm, m_bytes);
            e_lat = 1'b1;
         end
         m_out = ref_enc(m_bytes[m_off], m_off == 0);
         e_dv  = 1'b1;
         if (m_off == 15) begin
            m_crc = m_bytes[15];
            m_off = 0;
            if (!en) m_active = 1'b0;
         end else begin
            m_off++;
         end
      end
      @(posedge clk);
      #1;
      check("offset",  32'(tx_frm_offset), 32'(m_off));
      check("dv",      32'(phy_tx_dv),     32'(e_dv));
      check("symbol",  32'(phy_tx_out),    32'(m_out));
      check("latched", 32'(frame_latched), 32'(e_lat));
      check("crc",     32'(frame_crc),     32'(m_crc));
   endtask

   // Assert reset away from the edge, verify the asynchronous clear, release next cycle.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_dv",      32'(phy_tx_dv),     32'd0);
      check("rst_out",     32'(phy_tx_out),    32'd0);
      check("rst_offset",  32'(tx_frm_offset), 32'd0);
      check("rst_latched", 32'(frame_latched), 32'd0);
      check("rst_crc",     32'(frame_crc),     32'd0);
      m_active = 1'b0;
      m_off    = 0;
      m_rd     = 1'b0;
      m_out    = '0;
      m_crc    = '0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic rand_frame();
      case ($urandom_range(0, 3))
         0:       frm.comma_symbol = K28_5;
         1:       frm.comma_symbol = K28_6;
         default: frm.comma_symbol = 8'($urandom);
      endcase
      frm.frame_subtype = 8'($urandom);
      for (int i = 0; i < 13; i++) frm.data[i] = 8'($urandom);
   endtask

   typedef struct {
      logic [7:0] comma;
      logic [7:0] subtype;
      logic [9:0] sym0;     // comma code from RD-
      logic [9:0] sym1;     // subtype code, from RD+ after the comma
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [7:0] fa [16];
      logic [7:0] fb [16];
      int         cnt, cnt2;

      vecs[0] = '{8'hBC, 8'h00, 10'b0011111010, 10'b0110001011};
      vecs[1] = '{8'hDC, 8'h00, 10'b0011110110, 10'b0110001011};
      vecs[2] = '{8'h00, 8'h4A, 10'b0011111010, 10'b0101010101};
      vecs[3] = '{8'hFF, 8'hBC, 10'b0011111010, 10'b0011101010};
      vecs[4] = '{8'hDC, 8'h07, 10'b0011110110, 10'b0001110100};
      vecs[5] = '{8'hBC, 8'hF1, 10'b0011111010, 10'b1000110001};
      vecs[6] = '{8'hBC, 8'hEB, 10'b0011111010, 10'b1101001000};
      vecs[7] = '{8'hBC, 8'h03, 10'b0011111010, 10'b1100010100};
      vecs[8] = '{8'hBC, 8'h1F, 10'b0011111010, 10'b0101001011};

      reset_n   = 1'b0;
      tx_enable = 1'b0;
      sym_req   = 1'b0;
      frm       = '0;
      @(posedge clk);
      #1;

      // Vector table: first two symbols of a frame after reset
      for (int i = 0; i < 9; i++) begin
         do_reset();
         rand_frame();
         frm.comma_symbol  = vecs[i].comma;
         frm.frame_subtype = vecs[i].subtype;
         cycle(1'b1, 1'b0);
         cycle(1'b1, 1'b1);
         check($sformatf("vec%0d_sym0", i), 32'(phy_tx_out), 32'(vecs[i].sym0));
         check($sformatf("vec%0d_latched", i), 32'(frame_latched), 32'd1);
         cycle(1'b1, 1'b1);
         check($sformatf("vec%0d_sym1", i), 32'(phy_tx_out), 32'(vecs[i].sym1));
      end

      // Sparse requests: first symbol is K28.5 at RD-, one latch pulse per frame
      do_reset();
      rand_frame();
      frm.comma_symbol = K28_5;
      cycle(1'b1, 1'b0);
      cnt = 0;
      for (int i = 0; i < 80; i++) begin
         cycle(1'b1, (i % 5) == 4);
         if (frame_latched) cnt++;
         if (i == 4) check("sparse_first_k285", 32'(phy_tx_out), 32'(10'b0011111010));
      end
      check("sparse_latch_count", 32'(cnt), 32'd1);

      // Back-to-back requests for two full frames
      do_reset();
      rand_frame();
      frame_bytes(frm, fa);
      cycle(1'b1, 1'b0);
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cycle(1'b1, 1'b1);
         if (phy_tx_dv) cnt++;
      end
      check("b2b_dv_count", 32'(cnt), 32'd32);
      check("b2b_frame_crc", 32'(frame_crc), 32'(fa[15]));

      // All-zero payload gives a zero CRC
      frm = '0;
      frm.comma_symbol = K28_5;
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1);
      check("zero_frame_crc", 32'(frame_crc), 32'd0);

      // tx_enable dropped at offset 5: frame completes, then requests are ignored
      do_reset();
      rand_frame();
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
      cnt = 0;
      for (int i = 0; i < 11; i++) begin
         cycle(1'b0, 1'b1);
         if (phy_tx_dv) cnt++;
      end
      cnt2 = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1);
         if (phy_tx_dv) cnt2++;
      end
      check("drop_tail_symbols", 32'(cnt), 32'd11);
      check("idle_ignores_req", 32'(cnt2), 32'd0);

      // Input change after the snapshot affects only the next frame
      do_reset();
      rand_frame();
      frm.data[0] = 8'h11;
      frame_bytes(frm, fa);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      frm.data[0] = 8'h22;
      frame_bytes(frm, fb);
      for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1);
      check("snap_frame1_crc", 32'(frame_crc), 32'(fa[15]));
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1);
      check("snap_frame2_crc", 32'(frame_crc), 32'(fb[15]));

      // Reset at offset 9 abandons the frame; restart with comma at RD-
      do_reset();
      rand_frame();
      frm.comma_symbol = K28_5;
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1);
      do_reset();
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      check("post_reset_comma", 32'(phy_tx_out), 32'(10'b0011111010));

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) rand_frame();
         if ($urandom_range(0, 499) == 0) do_reset();
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
